triangle_wireframe: RTL and testbench
=====================================

TRIANGLE_WIREFRAME -- requirements
Module: triangle_wireframe

Interface
REQ-001 SHALL have parameter SCR_W, default 128: screen width in pixels; pixels with x >= SCR_W are clipped.
REQ-002 SHALL have parameter SCR_H, default 128: screen height in pixels; pixels with y >= SCR_H are clipped.
REQ-003 SHALL have parameter COLOR_W, default 8: colour word width.
REQ-004 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to draw the triangle on V1..V3; sampled only in IDLE.
REQ-007 V1, V2, V3  in  [1:0][15:0] each  screen vertices, signed Q8.8; index 0 = x, index 1 = y.
REQ-008 color  in  COLOR_W  line colour, latched on accepted start.
REQ-009 fb_ready  in  1  framebuffer accepts the presented pixel this cycle.
REQ-010 fb_we  out  1  pixel valid.
REQ-011 fb_x, fb_y  out  10 each  unsigned pixel coordinates.
REQ-012 fb_color  out  COLOR_W  pixel colour.
REQ-013 busy  out  1  triangle in progress.
REQ-014 done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL draw three Bresenham edges in order: V1->V2, V2->V3, V3->V1.
REQ-016 Each edge SHALL include both endpoints, giving max(|dx|,|dy|)+1 steps.
REQ-017 Shared vertices SHALL be written once per edge; no deduplication is performed.
REQ-018 Vertex-to-pixel conversion SHALL be signed(V[15:8]) + V[7] (round half up), held as 10-bit signed.
REQ-019 V1..V3 and color SHALL be latched on the accepted start; later input changes SHALL NOT affect the current triangle.
REQ-020 FSM states SHALL be IDLE, SETUP, STEP, DONE.
REQ-021 IDLE->SETUP on start; SETUP (1 cycle, fb_we=0) loads the edge endpoints, dx, dy, step signs and error term.
REQ-022 SETUP->STEP unconditionally.
REQ-023 STEP advances one pixel per handshake.
REQ-024 After the last step of edge 0 or 1, STEP SHALL go to SETUP; after the last step of edge 2, STEP SHALL go to DONE.
REQ-025 DONE SHALL go to IDLE after 1 cycle.
REQ-026 The first fb_we SHALL assert 2 cycles after the cycle start is sampled.
REQ-027 The edge-to-edge gap SHALL be 1 cycle.
REQ-028 Handshake: a pixel SHALL be consumed when fb_we && fb_ready.
REQ-029 While fb_we=1 && fb_ready=0, fb_x, fb_y, fb_color and fb_we SHALL hold stable.
REQ-030 Clipping: an on-path pixel with x<0, y<0, x>=SCR_W or y>=SCR_H SHALL keep fb_we=0 and SHALL advance in 1 cycle without regard to fb_ready.
REQ-031 busy SHALL be 1 from SETUP through the last STEP, and 0 in DONE and IDLE.
REQ-032 done SHALL be 1 only in DONE.
REQ-033 start while not IDLE SHALL be ignored, not queued.
REQ-034 A triangle whose vertices are all equal SHALL produce exactly 3 writes.

Reset
REQ-035 Reset SHALL immediately force IDLE with fb_we=0, busy=0, done=0, fb_x=0, fb_y=0, fb_color=0, and clear all latched vertices and edge index.
REQ-036 Reset mid-triangle SHALL abandon the triangle with no further writes.
REQ-037 The first start after Reset deasserts SHALL behave as from power-up.

Structure
REQ-038 Package render_pkg SHALL hold FXP_INT=8, FXP_FRAC=8, the pixel-coordinate type (10-bit signed), the vertex type ([1:0][15:0]) and the FSM state enum.
REQ-039 Sub-module line_stepper SHALL implement one Bresenham edge: load, x0/y0/x1/y1, advance, current x/y, last.
REQ-040 triangle_wireframe SHALL own the edge sequencing, rounding, clipping and handshake.

Verification
REQ-041 V1=(0A00,0A00), V2=(0D00,0A00), V3=(0A00,0D00), fb_ready=1 -> 12 writes, first (10,10),(11,10),(12,10),(13,10); first fb_we at start+2; done pulses once after the 12th write.
REQ-042 Same triangle, fb_ready low 5 cycles on the 2nd pixel -> (11,10) held stable 5 cycles; identical 12-write sequence.
REQ-043 V1=(FD00,0500), V2=(0200,0500), V3=(0200,0500) -> edge 0 writes only x=0,1,2 at y=5; clipped steps take 1 cycle each with fb_we=0.
REQ-044 V1 x=0A80 -> first fb_x=11; V1 x=0A7F -> first fb_x=10.
REQ-045 Reset pulsed during edge 1 -> fb_we, busy and done = 0 immediately; no writes follow; the next start redraws the full triangle.
REQ-046 All vertices (1400,1400), second start during busy -> exactly 3 writes at (20,20) and a single done pulse.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types for the wireframe renderer: fixed-point format, pixel coordinate,
// vertex layout and the sequencing FSM encoding.
package render_pkg;

  localparam int FXP_INT  = 8;
  localparam int FXP_FRAC = 8;
  localparam int PIX_W    = 10;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef logic [1:0][FXP_INT+FXP_FRAC-1:0] vertex_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STEP,
    S_DONE
  } state_t;

  // Round half up: integer part plus the first fractional bit.
  function automatic pix_t to_pix(input logic [FXP_INT+FXP_FRAC-1:0] c);
    logic signed [FXP_INT-1:0] ip;
    ip = c[FXP_INT+FXP_FRAC-1:FXP_FRAC];
    return pix_t'(ip) + pix_t'({1'b0, c[FXP_FRAC-1]});
  endfunction

endpackage

// File: rtl/line_stepper.sv
// One Bresenham edge, endpoints inclusive: load latches the endpoints, each
// advance moves to the next pixel until last is reached.
module line_stepper
  import render_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  input  pix_t x0,
  input  pix_t y0,
  input  pix_t x1,
  input  pix_t y1,
  output pix_t x,
  output pix_t y,
  output logic last
);

  localparam int EW = PIX_W + 3;
  typedef logic signed [EW-1:0] err_t;

  err_t ddx, ddy, adx, ady;
  err_t dx, dy, err, e2, err_nx;
  pix_t x_end, y_end, x_nx, y_nx;
  logic sx_neg, sy_neg;

  assign ddx  = err_t'(x1) - err_t'(x0);
  assign ddy  = err_t'(y1) - err_t'(y0);
  assign adx  = ddx[EW-1] ? -ddx : ddx;
  assign ady  = ddy[EW-1] ? -ddy : ddy;
  assign last = (x == x_end) && (y == y_end);

  // dy is held negated so both axis decisions compare against e2 directly.
  always_comb begin
    e2     = err <<< 1;
    err_nx = err;
    x_nx   = x;
    y_nx   = y;
    if (e2 >= dy) begin
      err_nx = err_nx + dy;
      x_nx   = sx_neg ? x - pix_t'(1) : x + pix_t'(1);
    end
    if (e2 <= dx) begin
      err_nx = err_nx + dx;
      y_nx   = sy_neg ? y - pix_t'(1) : y + pix_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      x_end  <= '0;
      y_end  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (load) begin
      x      <= x0;
      y      <= y0;
      x_end  <= x1;
      y_end  <= y1;
      dx     <= adx;
      dy     <= -ady;
      err    <= adx - ady;
      sx_neg <= ddx[EW-1];
      sy_neg <= ddy[EW-1];
    end else if (advance && !last) begin
      x   <= x_nx;
      y   <= y_nx;
      err <= err_nx;
    end
  end

endmodule

// File: rtl/triangle_wireframe.sv
// Draws the three edges of a triangle into a ready/valid pixel stream, skipping
// off-screen pixels in a single cycle each.
module triangle_wireframe
  import render_pkg::*;
#(
  parameter int SCR_W   = 128,
  parameter int SCR_H   = 128,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  vertex_t            v1,
  input  vertex_t            v2,
  input  vertex_t            v3,
  input  logic [COLOR_W-1:0] color,
  input  logic               fb_ready,
  output logic               fb_we,
  output logic [PIX_W-1:0]   fb_x,
  output logic [PIX_W-1:0]   fb_y,
  output logic [COLOR_W-1:0] fb_color,
  output logic               busy,
  output logic               done
);

  localparam int XW = PIX_W + 1;
  localparam logic signed [XW-1:0] X_LIM = XW'(SCR_W);
  localparam logic signed [XW-1:0] Y_LIM = XW'(SCR_H);

  state_t             state, state_nx;
  vertex_t            v1_q, v2_q, v3_q, va, vb;
  logic [COLOR_W-1:0] color_q;
  logic [1:0]         edge_idx;
  logic               accept, load, adv, edge_inc, on_screen, last;
  pix_t               cur_x, cur_y;

  always_comb begin
    va = v1_q;
    vb = v2_q;
    case (edge_idx)
      2'd1:    begin va = v2_q; vb = v3_q; end
      2'd2:    begin va = v3_q; vb = v1_q; end
      default: ;
    endcase
  end

  line_stepper u_step (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (adv),
    .x0      (to_pix(va[0])),
    .y0      (to_pix(va[1])),
    .x1      (to_pix(vb[0])),
    .y1      (to_pix(vb[1])),
    .x       (cur_x),
    .y       (cur_y),
    .last    (last)
  );

  assign on_screen = !cur_x[PIX_W-1] && !cur_y[PIX_W-1] &&
                     (XW'(cur_x) < X_LIM) && (XW'(cur_y) < Y_LIM);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load     = 1'b0;
    adv      = 1'b0;
    edge_inc = 1'b0;
    fb_we    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        busy     = 1'b1;
        load     = 1'b1;
        state_nx = S_STEP;
      end
      S_STEP: begin
        busy  = 1'b1;
        fb_we = on_screen;
        adv   = on_screen ? fb_ready : 1'b1;
        if (adv && last) begin
          if (edge_idx == 2'd2) begin
            state_nx = S_DONE;
          end else begin
            edge_inc = 1'b1;
            state_nx = S_SETUP;
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      v1_q     <= '0;
      v2_q     <= '0;
      v3_q     <= '0;
      color_q  <= '0;
      edge_idx <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        v1_q     <= v1;
        v2_q     <= v2;
        v3_q     <= v3;
        color_q  <= color;
        edge_idx <= '0;
      end else if (edge_inc) begin
        edge_idx <= edge_idx + 2'd1;
      end
    end
  end

  assign fb_x     = cur_x;
  assign fb_y     = cur_y;
  assign fb_color = color_q;

endmodule

// File: tb/tb_triangle_wireframe.sv
// Directed and randomized checks of triangle_wireframe against a pixel-list
// reference built from rounded vertex positions and textbook line stepping.
module tb_triangle_wireframe;
  import render_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, fb_ready, fb_we, busy, done;
  vertex_t    v1, v2, v3, tv1, tv2, tv3;
  logic [7:0] color, tcol, fb_color;
  logic [9:0] fb_x, fb_y;

  int total = 0;
  int bad   = 0;
  int got_x[$], got_y[$], got_c[$];
  int done_cnt = 0;
  int tl_x[$], tl_y[$], tl_k[$];
  int exp_x[$], exp_y[$];
  int exp_first;

  always #5 clk = ~clk;

  triangle_wireframe #(.SCR_W(128), .SCR_H(128), .COLOR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .v1       (v1),
    .v2       (v2),
    .v3       (v3),
    .color    (color),
    .fb_ready (fb_ready),
    .fb_we    (fb_we),
    .fb_x     (fb_x),
    .fb_y     (fb_y),
    .fb_color (fb_color),
    .busy     (busy),
    .done     (done)
  );

  always @(negedge clk) begin
    if (fb_we && fb_ready) begin
      got_x.push_back(int'(fb_x));
      got_y.push_back(int'(fb_y));
      got_c.push_back(int'(fb_color));
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Round to nearest, halves up: floor(value/256 + 1/2).
  function automatic int rnd_pix(input logic [15:0] c);
    int s;
    s = int'($signed(c));
    return (s + 128) >>> 8;
  endfunction

  function automatic logic [15:0] rnd_coord();
    int p, v;
    p = int'($urandom_range(0, 147)) - 20;
    v = p * 256 + int'($urandom_range(0, 255));
    return v[15:0];
  endfunction

  // Timeline kinds: 0 = setup cycle, 1 = visible pixel, 2 = clipped pixel.
  function automatic void add_edge(input int xa, input int ya, input int xb, input int yb);
    int dx, dy, sx, sy, err, e2, cx, cy;
    bit on;
    dx = (xb > xa) ? xb - xa : xa - xb;
    dy = (yb > ya) ? ya - yb : yb - ya;
    sx = (xa < xb) ? 1 : -1;
    sy = (ya < yb) ? 1 : -1;
    err = dx + dy;
    cx = xa;
    cy = ya;
    tl_k.push_back(0); tl_x.push_back(0); tl_y.push_back(0);
    forever begin
      on = (cx >= 0) && (cy >= 0) && (cx < 128) && (cy < 128);
      tl_k.push_back(on ? 1 : 2); tl_x.push_back(cx); tl_y.push_back(cy);
      if (on) begin exp_x.push_back(cx); exp_y.push_back(cy); end
      if (cx == xb && cy == yb) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endfunction

  function automatic void build_model();
    int px[3], py[3];
    tl_x.delete(); tl_y.delete(); tl_k.delete(); exp_x.delete(); exp_y.delete();
    px[0] = rnd_pix(tv1[0]); py[0] = rnd_pix(tv1[1]);
    px[1] = rnd_pix(tv2[0]); py[1] = rnd_pix(tv2[1]);
    px[2] = rnd_pix(tv3[0]); py[2] = rnd_pix(tv3[1]);
    for (int e = 0; e < 3; e++) add_edge(px[e], py[e], px[(e+1)%3], py[(e+1)%3]);
    exp_first = -1;
    for (int i = 0; i < tl_k.size(); i++)
      if (tl_k[i] == 1 && exp_first < 0) exp_first = i;
  endfunction

  task automatic launch();
    got_x.delete(); got_y.delete(); got_c.delete();
    done_cnt = 0;
    v1 = tv1; v2 = tv2; v3 = tv3; color = tcol;
    fb_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    v1 = $urandom; v2 = $urandom; v3 = $urandom; color = 8'($urandom);
  endtask

  task automatic run_tri(input string tag, input int stall_len, input bit rnd,
                         input int restart_j, input bit chk_timing);
    int j, first_j, done_j, stall_cnt, hx, hy;
    build_model();
    launch();
    j = 0; first_j = -1; done_j = -1; stall_cnt = 0; hx = 0; hy = 0;
    while (done_j < 0 && j < 5000) begin
      start = (j == restart_j);
      if (rnd) fb_ready = ($urandom_range(0, 3) != 0);
      else if (stall_len > 0 && fb_we && got_x.size() == 1 && stall_cnt < stall_len) fb_ready = 1'b0;
      else fb_ready = 1'b1;
      @(negedge clk);
      if (j == 0) begin
        check({tag, "_busy_setup"}, int'(busy), 1);
        check({tag, "_we_setup"}, int'(fb_we), 0);
      end
      if (fb_we && first_j < 0) first_j = j;
      if (!rnd && stall_len > 0 && !fb_ready && fb_we) begin
        if (stall_cnt == 0) begin
          hx = int'(fb_x); hy = int'(fb_y);
          check({tag, "_stall_x"}, hx, exp_x[1]);
          check({tag, "_stall_y"}, hy, exp_y[1]);
        end else begin
          check({tag, "_hold_x"}, int'(fb_x), hx);
          check({tag, "_hold_y"}, int'(fb_y), hy);
          check({tag, "_hold_c"}, int'(fb_color), int'(tcol));
        end
        stall_cnt++;
      end
      if (done) begin
        done_j = j;
        check({tag, "_busy_done"}, int'(busy), 0);
      end
      @(posedge clk); #1;
      j++;
    end
    start = 1'b0;
    fb_ready = 1'b1;
    check({tag, "_done_seen"}, int'(done_j >= 0), 1);
    if (stall_len > 0) check({tag, "_stall_cycles"}, stall_cnt, stall_len);
    if (chk_timing) begin
      check({tag, "_first_we"}, first_j, exp_first);
      check({tag, "_done_lat"}, done_j, tl_k.size());
    end
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_n_writes"}, got_x.size(), exp_x.size());
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      check({tag, "_px_x"}, got_x[i], exp_x[i]);
      check({tag, "_px_y"}, got_y[i], exp_y[i]);
      check({tag, "_px_c"}, got_c[i], int'(tcol));
    end
  endtask

  initial begin
    int j, nw;
    rst = 1'b1; start = 1'b0; fb_ready = 1'b1;
    v1 = '0; v2 = '0; v3 = '0; color = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(fb_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(fb_x), 0);
    check("rst_y", int'(fb_y), 0);
    check("rst_c", int'(fb_color), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Right triangle with legs of 3 pixels
    tv1 = {16'h0A00, 16'h0A00}; tv2 = {16'h0A00, 16'h0D00}; tv3 = {16'h0D00, 16'h0A00};
    tcol = 8'h5A;
    run_tri("basic", 0, 1'b0, -1, 1'b1);
    check("basic_count", got_x.size(), 12);
    check("basic_p0x", got_x[0], 10);
    check("basic_p3x", got_x[3], 13);
    check("basic_p3y", got_y[3], 10);

    tcol = 8'hC3;
    run_tri("stall", 5, 1'b0, -1, 1'b0);

    tv1 = {16'h0500, 16'hFD00}; tv2 = {16'h0500, 16'h0200}; tv3 = {16'h0500, 16'h0200};
    tcol = 8'h11;
    run_tri("clip", 0, 1'b0, -1, 1'b1);
    check("clip_p0x", got_x[0], 0);
    check("clip_p2x", got_x[2], 2);

    tv1 = {16'h0A00, 16'h0A80}; tv2 = {16'h0A00, 16'h0D00}; tv3 = {16'h0D00, 16'h0A00};
    run_tri("rnd_up", 0, 1'b0, -1, 1'b1);
    check("rnd_up_x", got_x[0], 11);
    tv1 = {16'h0A00, 16'h0A7F};
    run_tri("rnd_dn", 0, 1'b0, -1, 1'b1);
    check("rnd_dn_x", got_x[0], 10);

    // Reset while the second edge is being drawn
    tv1 = {16'h0A00, 16'h0A00}; tv2 = {16'h0A00, 16'h0D00}; tv3 = {16'h0D00, 16'h0A00};
    tcol = 8'h77;
    build_model();
    launch();
    j = 0;
    while (got_x.size() < 5 && j < 200) begin @(posedge clk); #1; j++; end
    check("mid_reach", got_x.size(), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_we", int'(fb_we), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_x", int'(fb_x), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nw = got_x.size();
    repeat (30) @(posedge clk);
    #1;
    check("mid_no_writes", got_x.size(), nw);
    check("mid_no_done", done_cnt, 0);
    check("mid_idle_busy", int'(busy), 0);
    run_tri("after_rst", 0, 1'b0, -1, 1'b1);

    // Degenerate triangle plus an ignored start while busy
    tv1 = {16'h1400, 16'h1400}; tv2 = tv1; tv3 = tv1;
    tcol = 8'h9E;
    run_tri("point", 0, 1'b0, 2, 1'b1);
    check("point_count", got_x.size(), 3);
    check("point_x", got_x[2], 20);
    check("point_y", got_y[2], 20);

    for (int t = 0; t < 6; t++) begin
      tv1 = {rnd_coord(), rnd_coord()};
      tv2 = {rnd_coord(), rnd_coord()};
      tv3 = {rnd_coord(), rnd_coord()};
      tcol = 8'($urandom);
      if (t < 4) run_tri("rand_bp", 0, 1'b1, -1, 1'b0);
      else run_tri("rand_fast", 0, 1'b0, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
